// File: rtl/clock_pkg.sv
// Shared encodings, limits and wrap helpers for the clock display time-set logic.
package clock_pkg;

    localparam logic [1:0] RUN    = 2'd0;
    localparam logic [1:0] SET_HH = 2'd1;
    localparam logic [1:0] SET_MM = 2'd2;
    localparam logic [1:0] SET_SS = 2'd3;

    localparam logic [4:0] HH_MAX = 5'd23;
    localparam logic [5:0] MS_MAX = 6'd59;

    // Bit positions inside digit_blank.
    localparam logic [1:0] FLD_SS = 2'd0;
    localparam logic [1:0] FLD_MM = 2'd1;
    localparam logic [1:0] FLD_HH = 2'd2;

    function automatic logic [4:0] hh_inc(input logic [4:0] v);
        return (v == HH_MAX) ? 5'd0 : v + 5'd1;
    endfunction

    function automatic logic [5:0] ms_inc(input logic [5:0] v);
        return (v == MS_MAX) ? 6'd0 : v + 6'd1;
    endfunction

    function automatic logic [1:0] field_of_state(input logic [1:0] st);
        case (st)
            SET_HH:  return FLD_HH;
            SET_MM:  return FLD_MM;
            default: return FLD_SS;
        endcase
    endfunction

endpackage

// File: rtl/blink_timebase.sv
// Blink phase generator: toggles phase_hidden every BLINK_DIV enabled cycles,
// held at the visible phase whenever disabled or restarted.
module blink_timebase #(
    parameter int BLINK_DIV = 50_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    input  logic restart,
    output logic phase_hidden
);

    localparam int CNT_W = $clog2(BLINK_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_DIV - 1);

    logic [CNT_W-1:0] cnt_reg;
    logic             phase_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg   <= '0;
            phase_reg <= 1'b0;
        end else if (restart || !enable) begin
            cnt_reg   <= '0;
            phase_reg <= 1'b0;
        end else if (cnt_reg == CNT_LAST) begin
            cnt_reg   <= '0;
            phase_reg <= ~phase_reg;
        end else begin
            cnt_reg   <= cnt_reg + 1'b1;
        end
    end

    assign phase_hidden = phase_reg;

endmodule

// File: rtl/time_set_ctrl.sv
// Time-of-day registers with a 1 Hz run mode and a three-field button-driven
// set mode; produces the blink mask for the field being edited.
module time_set_ctrl
    import clock_pkg::*;
#(
    parameter int BLINK_DIV = 50_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick_1hz,
    input  logic       btn_mode,
    input  logic       btn_inc,
    output logic [4:0] hh,
    output logic [5:0] mm,
    output logic [5:0] ss,
    output logic       set_active,
    output logic [2:0] digit_blank,
    output logic       sec_pulse
);

    logic [1:0] state_reg, state_next;
    logic [4:0] hh_reg, hh_next;
    logic [5:0] mm_reg, mm_next;
    logic [5:0] ss_reg, ss_next;
    logic       sec_pulse_reg, sec_pulse_next;
    logic       mode_prev_reg, inc_prev_reg;
    logic       mode_press, inc_press, inc_accept;
    logic       blink_restart, phase_hidden;

    assign mode_press = btn_mode & ~mode_prev_reg;
    assign inc_press  = btn_inc & ~inc_prev_reg;
    // A mode press in the same cycle swallows the inc press.
    assign inc_accept = inc_press & ~mode_press & (state_reg != RUN);

    always_comb begin
        state_next     = state_reg;
        hh_next        = hh_reg;
        mm_next        = mm_reg;
        ss_next        = ss_reg;
        sec_pulse_next = 1'b0;

        if (mode_press) begin
            state_next = state_reg + 2'd1;
        end

        if (state_reg == RUN) begin
            if (tick_1hz) begin
                sec_pulse_next = 1'b1;
                ss_next        = ms_inc(ss_reg);
                if (ss_reg == MS_MAX) begin
                    mm_next = ms_inc(mm_reg);
                    if (mm_reg == MS_MAX) begin
                        hh_next = hh_inc(hh_reg);
                    end
                end
            end
        end else if (inc_accept) begin
            case (state_reg)
                SET_HH:  hh_next = hh_inc(hh_reg);
                SET_MM:  mm_next = ms_inc(mm_reg);
                default: ss_next = ms_inc(ss_reg);
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= RUN;
            hh_reg        <= '0;
            mm_reg        <= '0;
            ss_reg        <= '0;
            sec_pulse_reg <= 1'b0;
            mode_prev_reg <= 1'b0;
            inc_prev_reg  <= 1'b0;
        end else begin
            state_reg     <= state_next;
            hh_reg        <= hh_next;
            mm_reg        <= mm_next;
            ss_reg        <= ss_next;
            sec_pulse_reg <= sec_pulse_next;
            mode_prev_reg <= btn_mode;
            inc_prev_reg  <= btn_inc;
        end
    end

    // Any edit or field change restarts blinking so the new value shows at once.
    assign blink_restart = mode_press | inc_accept;

    blink_timebase #(
        .BLINK_DIV (BLINK_DIV)
    ) u_blink (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (state_reg != RUN),
        .restart      (blink_restart),
        .phase_hidden (phase_hidden)
    );

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_blank
            assign digit_blank[gi] = phase_hidden && (state_reg != RUN)
                                  && (field_of_state(state_reg) == 2'(gi));
        end
    endgenerate

    assign hh         = hh_reg;
    assign mm         = mm_reg;
    assign ss         = ss_reg;
    assign sec_pulse  = sec_pulse_reg;
    assign set_active = (state_reg != RUN);

endmodule

// File: tb/tb_time_set_ctrl.sv
// Directed and random stimulus for time_set_ctrl against a seconds/field
// reference model of the clock.
module tb_time_set_ctrl;

    localparam int BLINK_DIV = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tick_1hz = 1'b0;
    logic       btn_mode = 1'b0;
    logic       btn_inc = 1'b0;
    logic [4:0] hh;
    logic [5:0] mm;
    logic [5:0] ss;
    logic       set_active;
    logic [2:0] digit_blank;
    logic       sec_pulse;

    time_set_ctrl #(
        .BLINK_DIV (BLINK_DIV)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .tick_1hz    (tick_1hz),
        .btn_mode    (btn_mode),
        .btn_inc     (btn_inc),
        .hh          (hh),
        .mm          (mm),
        .ss          (ss),
        .set_active  (set_active),
        .digit_blank (digit_blank),
        .sec_pulse   (sec_pulse)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    // Reference model: mode 0 = run, 1/2/3 = editing hours/minutes/seconds.
    int m_mode, m_h, m_m, m_s, m_since;
    bit m_pulse, m_mode_prev, m_inc_prev;

    task automatic check_val(input string tag, input int obs, input int exp);
        total++;
        if (obs != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_h = 0; m_m = 0; m_s = 0; m_since = 0;
        m_pulse = 0; m_mode_prev = 0; m_inc_prev = 0;
    endtask

    task automatic model_step();
        bit mp, ip, restart;
        int old_mode, secs;
        mp = btn_mode && !m_mode_prev;
        ip = btn_inc && !m_inc_prev;
        old_mode = m_mode;
        restart = 0;
        m_pulse = 0;
        if (old_mode == 0 && tick_1hz) begin
            secs = (m_h * 3600 + m_m * 60 + m_s + 1) % 86400;
            m_h = secs / 3600;
            m_m = (secs / 60) % 60;
            m_s = secs % 60;
            m_pulse = 1;
        end
        if (mp) begin
            m_mode = (old_mode + 1) % 4;
            restart = 1;
        end else if (ip && old_mode != 0) begin
            if (old_mode == 1) m_h = (m_h + 1) % 24;
            else if (old_mode == 2) m_m = (m_m + 1) % 60;
            else m_s = (m_s + 1) % 60;
            restart = 1;
        end
        if (restart) m_since = 0;
        else if (old_mode != 0) m_since++;
        m_mode_prev = btn_mode;
        m_inc_prev = btn_inc;
    endtask

    task automatic check_all(input string tag);
        int exp_blank;
        exp_blank = 0;
        if (m_mode != 0 && ((m_since / BLINK_DIV) % 2) == 1)
            exp_blank = 1 << (3 - m_mode);
        check_val({tag, ".hh"}, int'(hh), m_h);
        check_val({tag, ".mm"}, int'(mm), m_m);
        check_val({tag, ".ss"}, int'(ss), m_s);
        check_val({tag, ".set_active"}, int'(set_active), int'(m_mode != 0));
        check_val({tag, ".digit_blank"}, int'(digit_blank), exp_blank);
        check_val({tag, ".sec_pulse"}, int'(sec_pulse), int'(m_pulse));
    endtask

    task automatic cycle(input string tag, input bit t, input bit bm, input bit bi);
        tick_1hz = t;
        btn_mode = bm;
        btn_inc = bi;
        model_step();
        @(negedge clk);
        check_all(tag);
    endtask

    task automatic press_mode();
        cycle("mode", 0, 1, 0);
        cycle("mode_rel", 0, 0, 0);
    endtask

    task automatic press_inc(input int n);
        for (int i = 0; i < n; i++) begin
            cycle("inc", 0, 0, 1);
            cycle("inc_rel", 0, 0, 0);
        end
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        check_all("reset");
        rst_n = 1'b1;

        // Three ticks from reset
        for (int i = 0; i < 3; i++) begin
            cycle("tick", 1, 0, 0);
            check_val("tick.sec_pulse_seen", int'(sec_pulse), 1);
            cycle("tick_gap", 0, 0, 0);
        end
        check_val("three_ticks.ss", int'(ss), 3);

        // Preload 23:59:59 and roll over
        press_mode();
        press_inc(23);
        press_mode();
        press_inc(59);
        press_mode();
        press_inc(56);
        check_val("preload.ss", int'(ss), 59);
        press_mode();
        cycle("rollover", 1, 0, 0);
        check_val("rollover.hh", int'(hh), 0);
        check_val("rollover.mm", int'(mm), 0);
        check_val("rollover.ss", int'(ss), 0);

        // 25 increments in SET_HH with ticks arriving, which must be dropped
        press_mode();
        for (int i = 0; i < 25; i++) begin
            cycle("inc_tick", 1, 0, 1);
            cycle("inc_rel", 1, 0, 0);
        end
        check_val("hh_wrap.hh", int'(hh), 1);
        check_val("hh_wrap.ss", int'(ss), 0);

        // Blink in SET_MM
        press_mode();
        for (int i = 0; i < 3; i++) cycle("blink", 0, 0, 0);
        check_val("blink.on", int'(digit_blank), 3'b010);
        for (int i = 0; i < 10; i++) cycle("blink", 0, 0, 0);
        cycle("blink_inc", 0, 0, 1);
        check_val("blink.inc_visible", int'(digit_blank), 0);
        for (int i = 0; i < 10; i++) cycle("blink", 0, 0, 0);

        // Back around to SET_HH, then mode and inc together
        press_mode();
        press_mode();
        press_mode();
        cycle("both", 0, 1, 1);
        check_val("both.hh", int'(hh), 1);
        for (int i = 0; i < 100; i++) cycle("hold", 0, 0, 1);
        cycle("hold_rel", 0, 0, 0);
        check_val("hold.mm", int'(mm), 1);

        // Reset in the middle of SET_SS
        press_mode();
        while (m_s != 42) press_inc(1);
        check_val("pre_reset.ss", int'(ss), 42);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_val("async_rst.hh", int'(hh), 0);
        check_val("async_rst.mm", int'(mm), 0);
        check_val("async_rst.ss", int'(ss), 0);
        check_val("async_rst.digit_blank", int'(digit_blank), 0);
        check_val("async_rst.set_active", int'(set_active), 0);
        @(negedge clk);
        check_all("in_reset");
        rst_n = 1'b1;

        // Random traffic
        for (int i = 0; i < 4000; i++) begin
            bit t, bm, bi;
            t = ($urandom_range(0, 7) == 0);
            bm = ($urandom_range(0, 19) == 0) ? !btn_mode : btn_mode;
            bi = ($urandom_range(0, 4) == 0) ? !btn_inc : btn_inc;
            cycle("rand", t, bm, bi);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
